conv_ctrl: RTL and testbench

Sequencing controller for the 3x3 convolution datapath: one `start` pulse runs a full convolution of an IMG_W x IMG_H x IN_CH feature map for 4 output channels. It drives every enable and address the datapath needs: input SRAM, line-buffer shift, kernel and bias SRAMs, and partial-sum SRAM read-modify-write. It also flags the cycles on which final post-bias/ReLU outputs are valid. It sits directly upstream of the convolution top-level and replaces testbench-driven control.

---
 rtl/conv_ctrl.sv | 257 +++++++++++++++++++++++++
 tb/tb_conv_ctrl.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_ctrl.sv
// Sequencing controller for the 3x3 convolution datapath: one start pulse clears the
// partial-sum SRAM, then streams every input channel through the line buffer.
module conv_ctrl #(
  parameter int IMG_W = 16,
  parameter int IMG_H = 16,
  parameter int IN_CH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  bias_sel,
  output logic        input_sram_en,
  output logic [11:0] input_sram_rd_addr,
  output logic        lb_en,
  output logic        kernel_sram_en,
  output logic [8:0]  kernel_rd_addr,
  output logic        bias_sram_en,
  output logic [3:0]  bias_rd_addr,
  output logic        ps_sram_en,
  output logic        ps_sram_wr_en,
  output logic        ps_sram_rst_en,
  output logic [11:0] ps_sram_addr,
  output logic        out_valid,
  output logic [11:0] out_addr,
  output logic        busy,
  output logic        done,
  output logic [2:0]  state_dbg
);

  localparam int OW = IMG_W - 2;
  localparam int OH = IMG_H - 2;
  localparam logic [11:0] N_LAST   = 12'(OW * OH - 1);
  localparam logic [11:0] HW       = 12'(IMG_W * IMG_H);
  localparam logic [11:0] PIX_LAST = 12'(IMG_W * IMG_H - 1);
  localparam logic [11:0] COL_LAST = 12'(IMG_W - 1);
  localparam logic [8:0]  CH_LAST  = 9'(IN_CH - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CLEAR  = 3'd1;
  localparam logic [2:0] S_KLOAD  = 3'd2;
  localparam logic [2:0] S_STREAM = 3'd3;
  localparam logic [2:0] S_TAIL   = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  logic [2:0]  state, nxt_state;
  logic [11:0] clr_cnt, nxt_clr;
  logic        ph, nxt_ph;
  logic [11:0] pix, nxt_pix;
  logic [11:0] row, nxt_row;
  logic [11:0] col, nxt_col;
  logic [8:0]  ch, nxt_ch;
  logic [11:0] ch_base, nxt_base;
  logic [11:0] win, nxt_win;
  logic [3:0]  bias_q, nxt_bias;

  logic        o_in_en, o_lb, o_k_en, o_b_en, o_ps_en, o_ps_wr, o_ps_rst, o_ov, o_busy, o_done;
  logic [11:0] o_in_addr, o_ps_addr, o_oaddr;
  logic [8:0]  o_k_addr;
  logic [3:0]  o_b_addr;
  logic        rd_now;

  assign state_dbg = state;
  // A PS read issued this cycle must be written back next cycle.
  assign rd_now = !ps_sram_en && !ps_sram_wr_en;

  always_comb begin
    nxt_state = state;
    nxt_clr   = clr_cnt;
    nxt_ph    = ph;
    nxt_pix   = pix;
    nxt_row   = row;
    nxt_col   = col;
    nxt_ch    = ch;
    nxt_base  = ch_base;
    nxt_win   = win;
    nxt_bias  = bias_q;
    case (state)
      S_IDLE: begin
        if (start) begin
          nxt_state = S_CLEAR;
          nxt_clr   = 12'd0;
          nxt_ph    = 1'b0;
          nxt_pix   = 12'd0;
          nxt_row   = 12'd0;
          nxt_col   = 12'd0;
          nxt_ch    = 9'd0;
          nxt_base  = 12'd0;
          nxt_win   = 12'd0;
          nxt_bias  = bias_sel;
        end
      end
      S_CLEAR: begin
        if (clr_cnt == N_LAST) nxt_state = S_KLOAD;
        else nxt_clr = clr_cnt + 12'd1;
      end
      S_KLOAD: begin
        nxt_state = S_STREAM;
        nxt_ph    = 1'b0;
        nxt_pix   = 12'd0;
        nxt_row   = 12'd0;
        nxt_col   = 12'd0;
        nxt_win   = 12'd0;
      end
      S_STREAM: begin
        if (!ph) begin
          nxt_ph = 1'b1;
        end else begin
          nxt_ph = 1'b0;
          if (row >= 12'd2 && col >= 12'd2) nxt_win = win + 12'd1;
          if (pix == PIX_LAST) begin
            nxt_state = S_TAIL;
          end else begin
            nxt_pix = pix + 12'd1;
            if (col == COL_LAST) begin
              nxt_col = 12'd0;
              nxt_row = row + 12'd1;
            end else begin
              nxt_col = col + 12'd1;
            end
          end
        end
      end
      S_TAIL: begin
        if (ch == CH_LAST) begin
          nxt_state = S_DONE;
        end else begin
          nxt_ch    = ch + 9'd1;
          nxt_base  = ch_base + HW;
          nxt_state = S_KLOAD;
        end
      end
      S_DONE:  nxt_state = S_IDLE;
      default: nxt_state = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next-cycle state so they can be registered.
  always_comb begin
    o_in_en   = 1'b1;
    o_in_addr = input_sram_rd_addr;
    o_lb      = 1'b0;
    o_k_en    = 1'b1;
    o_k_addr  = kernel_rd_addr;
    o_b_en    = 1'b1;
    o_b_addr  = bias_rd_addr;
    o_ps_en   = 1'b1;
    o_ps_wr   = 1'b0;
    o_ps_rst  = 1'b0;
    o_ps_addr = ps_sram_addr;
    o_ov      = 1'b0;
    o_oaddr   = out_addr;
    o_busy    = (nxt_state != S_IDLE);
    o_done    = (nxt_state == S_DONE);
    case (nxt_state)
      S_IDLE: begin
        o_in_addr = 12'd0;
        o_k_addr  = 9'd0;
        o_b_addr  = 4'd0;
        o_ps_addr = 12'd0;
        o_oaddr   = 12'd0;
      end
      S_CLEAR: begin
        o_ps_en   = 1'b0;
        o_ps_wr   = 1'b1;
        o_ps_rst  = 1'b1;
        o_ps_addr = nxt_clr;
      end
      S_KLOAD: begin
        o_k_en   = 1'b0;
        o_k_addr = nxt_ch;
        if (nxt_ch == 9'd0) begin
          o_b_en   = 1'b0;
          o_b_addr = nxt_bias;
        end
      end
      S_STREAM: begin
        if (!nxt_ph) begin
          o_in_en   = 1'b0;
          o_in_addr = nxt_base + nxt_pix;
        end else begin
          o_lb = 1'b1;
          if (nxt_row >= 12'd2 && nxt_col >= 12'd2) begin
            o_ps_en   = 1'b0;
            o_ps_addr = nxt_win;
          end
        end
      end
      default: ;
    endcase
    if (rd_now && (nxt_state == S_STREAM || nxt_state == S_TAIL)) begin
      o_ps_en  = 1'b0;
      o_ps_wr  = 1'b1;
      o_ps_rst = 1'b0;
      if (nxt_ch == CH_LAST) begin
        o_ov    = 1'b1;
        o_oaddr = ps_sram_addr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state              <= S_IDLE;
      clr_cnt            <= 12'd0;
      ph                 <= 1'b0;
      pix                <= 12'd0;
      row                <= 12'd0;
      col                <= 12'd0;
      ch                 <= 9'd0;
      ch_base            <= 12'd0;
      win                <= 12'd0;
      bias_q             <= 4'd0;
      input_sram_en      <= 1'b1;
      input_sram_rd_addr <= 12'd0;
      lb_en              <= 1'b0;
      kernel_sram_en     <= 1'b1;
      kernel_rd_addr     <= 9'd0;
      bias_sram_en       <= 1'b1;
      bias_rd_addr       <= 4'd0;
      ps_sram_en         <= 1'b1;
      ps_sram_wr_en      <= 1'b0;
      ps_sram_rst_en     <= 1'b0;
      ps_sram_addr       <= 12'd0;
      out_valid          <= 1'b0;
      out_addr           <= 12'd0;
      busy               <= 1'b0;
      done               <= 1'b0;
    end else begin
      state              <= nxt_state;
      clr_cnt            <= nxt_clr;
      ph                 <= nxt_ph;
      pix                <= nxt_pix;
      row                <= nxt_row;
      col                <= nxt_col;
      ch                 <= nxt_ch;
      ch_base            <= nxt_base;
      win                <= nxt_win;
      bias_q             <= nxt_bias;
      input_sram_en      <= o_in_en;
      input_sram_rd_addr <= o_in_addr;
      lb_en              <= o_lb;
      kernel_sram_en     <= o_k_en;
      kernel_rd_addr     <= o_k_addr;
      bias_sram_en       <= o_b_en;
      bias_rd_addr       <= o_b_addr;
      ps_sram_en         <= o_ps_en;
      ps_sram_wr_en      <= o_ps_wr;
      ps_sram_rst_en     <= o_ps_rst;
      ps_sram_addr       <= o_ps_addr;
      out_valid          <= o_ov;
      out_addr           <= o_oaddr;
      busy               <= o_busy;
      done               <= o_done;
    end
  end

endmodule

// File: tb/tb_conv_ctrl.sv
// Bench for conv_ctrl: a default-sized instance (index 0) and a 4x4x2 instance (index 1)
// share clock and reset; a negedge monitor gathers per-instance statistics.
module tb_conv_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [1:0] start_v = 2'b00;
  logic [3:0] bias_sel = 4'd0;
  logic mon_clr = 1'b0;

  always #5 clk = ~clk;

  logic [1:0] in_en_o, lb_o, k_en_o, b_en_o, ps_en_o, ps_wr_o, ps_rst_o, ov_o, busy_o, done_o;
  logic [1:0][11:0] in_addr_o, ps_addr_o, o_addr_o;
  logic [1:0][8:0]  k_addr_o;
  logic [1:0][3:0]  b_addr_o;
  logic [1:0][2:0]  st_o;

  conv_ctrl dut_big (
    .clk(clk), .reset(reset), .start(start_v[0]), .bias_sel(bias_sel),
    .input_sram_en(in_en_o[0]), .input_sram_rd_addr(in_addr_o[0]), .lb_en(lb_o[0]),
    .kernel_sram_en(k_en_o[0]), .kernel_rd_addr(k_addr_o[0]),
    .bias_sram_en(b_en_o[0]), .bias_rd_addr(b_addr_o[0]),
    .ps_sram_en(ps_en_o[0]), .ps_sram_wr_en(ps_wr_o[0]), .ps_sram_rst_en(ps_rst_o[0]),
    .ps_sram_addr(ps_addr_o[0]), .out_valid(ov_o[0]), .out_addr(o_addr_o[0]),
    .busy(busy_o[0]), .done(done_o[0]), .state_dbg(st_o[0])
  );

  conv_ctrl #(.IMG_W(4), .IMG_H(4), .IN_CH(2)) dut_small (
    .clk(clk), .reset(reset), .start(start_v[1]), .bias_sel(bias_sel),
    .input_sram_en(in_en_o[1]), .input_sram_rd_addr(in_addr_o[1]), .lb_en(lb_o[1]),
    .kernel_sram_en(k_en_o[1]), .kernel_rd_addr(k_addr_o[1]),
    .bias_sram_en(b_en_o[1]), .bias_rd_addr(b_addr_o[1]),
    .ps_sram_en(ps_en_o[1]), .ps_sram_wr_en(ps_wr_o[1]), .ps_sram_rst_en(ps_rst_o[1]),
    .ps_sram_addr(ps_addr_o[1]), .out_valid(ov_o[1]), .out_addr(o_addr_o[1]),
    .busy(busy_o[1]), .done(done_o[1]), .state_dbg(st_o[1])
  );

  int checks = 0;
  int fails = 0;

  int busy_cnt[2], done_cnt[2], rd_cnt[2], wr_cnt[2], clr_cnt[2], pair_err[2], bias_cnt[2];
  logic [3:0]  bias_seen[2];
  logic [11:0] rd_addr_m[2];
  logic        rd_pend[2];
  logic [8:0]  last_k[2];
  logic        first_pend[2];
  logic [11:0] first_ch2, last_in;
  logic [11:0] exp_q[$], exp_s_q[$], obs_q[$], obs_s_q[$], clr_s_q[$], rd_s_q[$];

  // Monitor: counts events and flags protocol violations for both instances.
  always @(negedge clk) begin
    if (mon_clr) begin
      for (int i = 0; i < 2; i++) begin
        busy_cnt[i] = 0; done_cnt[i] = 0; rd_cnt[i] = 0; wr_cnt[i] = 0;
        clr_cnt[i] = 0; pair_err[i] = 0; bias_cnt[i] = 0; bias_seen[i] = 4'd0;
        rd_addr_m[i] = 12'd0; rd_pend[i] = 1'b0; last_k[i] = 9'd0; first_pend[i] = 1'b0;
      end
      first_ch2 = 12'hfff;
      last_in = 12'd0;
      obs_q.delete(); obs_s_q.delete(); clr_s_q.delete(); rd_s_q.delete();
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (busy_o[i]) busy_cnt[i]++;
        if (done_o[i]) done_cnt[i]++;
        if (rd_pend[i] && !(!ps_en_o[i] && ps_wr_o[i] && !ps_rst_o[i] && ps_addr_o[i] == rd_addr_m[i]))
          pair_err[i]++;
        rd_pend[i] = !ps_en_o[i] && !ps_wr_o[i];
        if (rd_pend[i]) begin
          rd_cnt[i]++;
          rd_addr_m[i] = ps_addr_o[i];
          if (i == 1) rd_s_q.push_back(ps_addr_o[i]);
        end
        if (!ps_en_o[i] && ps_wr_o[i] && ps_rst_o[i]) begin
          clr_cnt[i]++;
          if (i == 1) clr_s_q.push_back(ps_addr_o[i]);
        end
        if (!ps_en_o[i] && ps_wr_o[i] && !ps_rst_o[i]) wr_cnt[i]++;
        if (!ps_en_o[i] && ps_wr_o[i] && lb_o[i]) pair_err[i]++;
        if (!in_en_o[i] && lb_o[i]) pair_err[i]++;
        if (ov_o[i] && !(!ps_en_o[i] && ps_wr_o[i] && !ps_rst_o[i] && o_addr_o[i] == ps_addr_o[i]))
          pair_err[i]++;
        if (ov_o[i]) begin
          if (i == 0) obs_q.push_back(o_addr_o[i]);
          else obs_s_q.push_back(o_addr_o[i]);
        end
        if (!b_en_o[i]) begin
          bias_cnt[i]++;
          bias_seen[i] = b_addr_o[i];
        end
        if (!k_en_o[i]) begin
          last_k[i] = k_addr_o[i];
          first_pend[i] = 1'b1;
        end
        if (!in_en_o[i] && i == 0) begin
          if (first_pend[i] && last_k[i] == 9'd2) first_ch2 = in_addr_o[i];
          last_in = in_addr_o[i];
        end
        if (!in_en_o[i]) first_pend[i] = 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    mon_clr = 1'b1;
    step();
    mon_clr = 1'b0;
  endtask

  task automatic pulse_start(input int i);
    start_v[i] = 1'b1;
    step();
    start_v[i] = 1'b0;
  endtask

  task automatic wait_done(input int i, input int budget);
    for (int n = 0; n < budget; n++) begin
      step();
      if (done_o[i]) break;
    end
    repeat (3) step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    clear_mon();
    for (int n = 0; n < 20; n++) begin
      step();
      for (int i = 0; i < 2; i++) begin
        checks++;
        if ({in_en_o[i], k_en_o[i], b_en_o[i], ps_en_o[i], lb_o[i], ps_wr_o[i], ps_rst_o[i],
             ov_o[i], busy_o[i], done_o[i]} !== 10'b1111000000) begin
          fails++;
          $display("FAIL reset_ctrl dut%0d cycle %0d: got %b want 1111000000", i, n,
                   {in_en_o[i], k_en_o[i], b_en_o[i], ps_en_o[i], lb_o[i], ps_wr_o[i],
                    ps_rst_o[i], ov_o[i], busy_o[i], done_o[i]});
        end
        checks++;
        if ({in_addr_o[i], ps_addr_o[i], o_addr_o[i], k_addr_o[i], b_addr_o[i]} !== 49'd0) begin
          fails++;
          $display("FAIL reset_addr dut%0d cycle %0d: got nonzero address, want 0", i, n);
        end
      end
    end
  endtask

  task automatic test_small_map();
    logic [11:0] a, e;
    clear_mon();
    for (int k = 0; k < 4; k++) exp_s_q.push_back(12'(k));
    pulse_start(1);
    wait_done(1, 200);
    checks++;
    if (busy_cnt[1] !== 73) begin
      fails++; $display("FAIL small_busy: got %0d want 73", busy_cnt[1]);
    end
    checks++;
    if (done_cnt[1] !== 1) begin
      fails++; $display("FAIL small_done: got %0d want 1", done_cnt[1]);
    end
    checks++;
    if (clr_s_q.size() !== 4) begin
      fails++; $display("FAIL small_clr_cnt: got %0d want 4", clr_s_q.size());
    end
    for (int k = 0; k < 4 && clr_s_q.size() > 0; k++) begin
      a = clr_s_q.pop_front();
      checks++;
      if (a !== 12'(k)) begin
        fails++; $display("FAIL small_clr_addr %0d: got %0d want %0d", k, a, k);
      end
    end
    checks++;
    if (rd_cnt[1] !== 8 || wr_cnt[1] !== 8) begin
      fails++; $display("FAIL small_pairs: got rd %0d wr %0d want 8 8", rd_cnt[1], wr_cnt[1]);
    end
    for (int k = 0; k < 8 && rd_s_q.size() > 0; k++) begin
      a = rd_s_q.pop_front();
      checks++;
      if (a !== 12'(k % 4)) begin
        fails++; $display("FAIL small_rd_addr %0d: got %0d want %0d", k, a, k % 4);
      end
    end
    checks++;
    if (pair_err[1] !== 0) begin
      fails++; $display("FAIL small_pairing: got %0d violations want 0", pair_err[1]);
    end
    while (exp_s_q.size() > 0) begin
      e = exp_s_q.pop_front();
      checks++;
      if (obs_s_q.size() == 0) begin
        fails++; $display("FAIL small_out_addr: got no out_valid want addr %0d", e);
      end else begin
        a = obs_s_q.pop_front();
        if (a !== e) begin
          fails++; $display("FAIL small_out_addr: got %0d want %0d", a, e);
        end
      end
    end
    checks++;
    if (obs_s_q.size() !== 0) begin
      fails++; $display("FAIL small_out_extra: got %0d extra outputs want 0", obs_s_q.size());
    end
  endtask

  task automatic test_defaults();
    logic [11:0] a, e;
    bias_sel = 4'd5;
    clear_mon();
    for (int k = 0; k < 196; k++) exp_q.push_back(12'(k));
    pulse_start(0);
    bias_sel = 4'd9;
    wait_done(0, 3000);
    checks++;
    if (busy_cnt[0] !== 2253) begin
      fails++; $display("FAIL def_busy: got %0d want 2253", busy_cnt[0]);
    end
    checks++;
    if (done_cnt[0] !== 1) begin
      fails++; $display("FAIL def_done: got %0d want 1", done_cnt[0]);
    end
    checks++;
    if (clr_cnt[0] !== 196) begin
      fails++; $display("FAIL def_clear: got %0d want 196", clr_cnt[0]);
    end
    checks++;
    if (rd_cnt[0] !== 784 || wr_cnt[0] !== 784) begin
      fails++; $display("FAIL def_pairs: got rd %0d wr %0d want 784 784", rd_cnt[0], wr_cnt[0]);
    end
    checks++;
    if (pair_err[0] !== 0) begin
      fails++; $display("FAIL def_pairing: got %0d violations want 0", pair_err[0]);
    end
    checks++;
    if (first_ch2 !== 12'd512) begin
      fails++; $display("FAIL def_ch2_first: got %0d want 512", first_ch2);
    end
    checks++;
    if (last_in !== 12'd1023) begin
      fails++; $display("FAIL def_last_in: got %0d want 1023", last_in);
    end
    checks++;
    if (bias_cnt[0] !== 1 || bias_seen[0] !== 4'd5) begin
      fails++; $display("FAIL def_bias: got %0d reads addr %0d want 1 reads addr 5",
                        bias_cnt[0], bias_seen[0]);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        fails++; $display("FAIL def_out_addr: got no out_valid want addr %0d", e);
      end else begin
        a = obs_q.pop_front();
        if (a !== e) begin
          fails++; $display("FAIL def_out_addr: got %0d want %0d", a, e);
        end
      end
    end
    checks++;
    if (obs_q.size() !== 0) begin
      fails++; $display("FAIL def_out_extra: got %0d extra outputs want 0", obs_q.size());
    end
  endtask

  task automatic test_start_ignored();
    clear_mon();
    pulse_start(0);
    repeat (300 + $urandom_range(0, 200)) step();
    pulse_start(0);
    wait_done(0, 3000);
    repeat (5) step();
    checks++;
    if (busy_cnt[0] !== 2253 || done_cnt[0] !== 1) begin
      fails++; $display("FAIL start_ignored: got busy %0d done %0d want 2253 1",
                        busy_cnt[0], done_cnt[0]);
    end
    checks++;
    if (obs_q.size() !== 196) begin
      fails++; $display("FAIL start_ignored_out: got %0d outputs want 196", obs_q.size());
    end
    checks++;
    if (busy_o[0] !== 1'b0) begin
      fails++; $display("FAIL start_ignored_idle: got busy %b want 0", busy_o[0]);
    end
  endtask

  task automatic test_reset_mid_stream();
    clear_mon();
    pulse_start(0);
    repeat (500 + $urandom_range(0, 300)) step();
    reset = 1'b1;
    step();
    checks++;
    if ({in_en_o[0], k_en_o[0], b_en_o[0], ps_en_o[0], lb_o[0], ps_wr_o[0], ps_rst_o[0],
         ov_o[0], busy_o[0], done_o[0]} !== 10'b1111000000) begin
      fails++; $display("FAIL reset_mid_ctrl: got %b want 1111000000",
                        {in_en_o[0], k_en_o[0], b_en_o[0], ps_en_o[0], lb_o[0], ps_wr_o[0],
                         ps_rst_o[0], ov_o[0], busy_o[0], done_o[0]});
    end
    checks++;
    if ({in_addr_o[0], ps_addr_o[0], o_addr_o[0], k_addr_o[0], b_addr_o[0]} !== 49'd0) begin
      fails++; $display("FAIL reset_mid_addr: got nonzero address want 0");
    end
    reset = 1'b0;
    step();
    clear_mon();
    pulse_start(0);
    wait_done(0, 3000);
    checks++;
    if (busy_cnt[0] !== 2253 || done_cnt[0] !== 1) begin
      fails++; $display("FAIL reset_mid_rerun: got busy %0d done %0d want 2253 1",
                        busy_cnt[0], done_cnt[0]);
    end
    checks++;
    if (pair_err[0] !== 0 || obs_q.size() !== 196) begin
      fails++; $display("FAIL reset_mid_rerun_out: got %0d violations %0d outputs want 0 196",
                        pair_err[0], obs_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_small_map();
    test_defaults();
    test_start_ignored();
    test_reset_mid_stream();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
